// File: rtl/prefetch_if_stage.sv
// Instruction prefetch stage: issues in-order word fetches to instruction
// memory, buffers returned words in a small FIFO and presents them to ID.
// Branches flush the buffer and discard responses still in flight.
// Optional bubble counter is built when IF_PERF_CNT_EN is defined.
module prefetch_if_stage #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] boot_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        id_ready_i,
    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] pc_id_o,
    output logic [31:0] fetch_bubbles_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t MAX_C   = cnt_t'(MAX_OUTSTANDING);

    typedef enum logic {BOOT, RUN} state_e;

    state_e          state_q;
    logic [31:0]     fetch_pc_q;   // address of the next request
    logic [31:0]     rsp_pc_q;     // address of the next non-discarded response
    cnt_t            occ_q;        // FIFO occupancy
    cnt_t            outst_q;      // granted but not yet returned
    cnt_t            disc_q;       // in-flight responses to drop
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [31:0]     mem_pc_q   [DEPTH];
    logic [31:0]     mem_data_q [DEPTH];

    logic [CW:0]     inflight;
    logic            req;
    logic            gnt_fire;
    logic            rsp_ok;
    logic            push;
    logic            pop;
    logic            valid;
    cnt_t            outst_d;
    logic [31:0]     branch_tgt;
    logic [31:0]     boot_tgt;

    // Request gating, FIFO handshakes and next outstanding count
    always_comb begin
        inflight   = {1'b0, occ_q} + {1'b0, outst_q};
        req        = (state_q == RUN) && (inflight < {1'b0, DEPTH_C}) && (outst_q < MAX_C);
        gnt_fire   = req & instr_gnt_i;
        // a response with nothing outstanding is a protocol error and is ignored
        rsp_ok     = instr_rvalid_i && (outst_q != '0);
        push       = rsp_ok && (disc_q == '0) && !branch_i;
        valid      = (occ_q != '0);
        pop        = valid && id_ready_i && !branch_i;
        outst_d    = outst_q + cnt_t'(gnt_fire) - cnt_t'(rsp_ok);
        branch_tgt = branch_addr_i & ~32'h3;
        boot_tgt   = boot_addr_i & ~32'h3;
    end

    // FSM, fetch/response PCs, counters and FIFO pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BOOT;
            fetch_pc_q <= '0;
            rsp_pc_q   <= '0;
            occ_q      <= '0;
            outst_q    <= '0;
            disc_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q <= RUN;
            outst_q <= outst_d;
            if (state_q == BOOT) begin
                fetch_pc_q <= boot_tgt;
                rsp_pc_q   <= boot_tgt;
            end else if (branch_i) begin
                fetch_pc_q <= branch_tgt;
                rsp_pc_q   <= branch_tgt;
            end else begin
                if (gnt_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
                if (push)     rsp_pc_q   <= rsp_pc_q + 32'd4;
            end
            // everything still in flight after a branch belongs to the old path
            if (branch_i)
                disc_q <= outst_d;
            else if (rsp_ok && (disc_q != '0))
                disc_q <= disc_q - cnt_t'(1);
            if (branch_i) begin
                occ_q    <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                occ_q <= occ_q + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    // FIFO storage; contents are only observed while occupancy is non-zero
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
            mem_data_q[wr_ptr_q] <= instr_rdata_i;
        end
    end

    assign instr_req_o      = req;
    assign instr_addr_o     = fetch_pc_q;
    assign instr_valid_id_o = valid;
    assign instr_rdata_id_o = valid ? mem_data_q[rd_ptr_q] : 32'h0;
    assign pc_id_o          = valid ? mem_pc_q[rd_ptr_q]   : 32'h0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] bubbles_q;

    // Count cycles where ID could take an instruction but none is ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            bubbles_q <= '0;
        else if ((state_q == RUN) && id_ready_i && !valid && (bubbles_q != 32'hFFFF_FFFF))
            bubbles_q <= bubbles_q + 32'd1;
    end

    assign fetch_bubbles_o = bubbles_q;
`else
    assign fetch_bubbles_o = 32'h0;
`endif

endmodule

// File: tb/tb_prefetch_if_stage.sv
// Randomized scoreboard bench for prefetch_if_stage: a memory model answers
// requests in order, a reference model tracks the expected instruction
// stream per branch epoch, and a separate monitor checks what ID sees.
module tb_prefetch_if_stage;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] boot_addr_i = 32'h80;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        id_ready_i = 1'b0;
    logic        instr_valid_id_o;
    logic [31:0] instr_rdata_id_o;
    logic [31:0] pc_id_o;
    logic [31:0] fetch_bubbles_o;

    prefetch_if_stage #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .boot_addr_i      (boot_addr_i),
        .instr_req_o      (instr_req_o),
        .instr_addr_o     (instr_addr_o),
        .instr_gnt_i      (instr_gnt_i),
        .instr_rvalid_i   (instr_rvalid_i),
        .instr_rdata_i    (instr_rdata_i),
        .branch_i         (branch_i),
        .branch_addr_i    (branch_addr_i),
        .id_ready_i       (id_ready_i),
        .instr_valid_id_o (instr_valid_id_o),
        .instr_rdata_id_o (instr_rdata_id_o),
        .pc_id_o          (pc_id_o),
        .fetch_bubbles_o  (fetch_bubbles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          ep;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mreq_t       pend[$];   // granted requests awaiting a response
    exp_t        sb[$];     // expected contents of the prefetch buffer, head first
    int          checks = 0;
    int          errors = 0;
    int          epoch = 0;
    bit          run = 0;
    logic [31:0] mpc = '0;
    logic [31:0] bub = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: compares ID-side outputs with the scoreboard every cycle
    initial begin
        bit exp_valid;
        forever begin
            @(negedge clk_i);
            #2;
            if (!rst_ni) begin
                chk("rst_req",   instr_req_o, 0);
                chk("rst_addr",  instr_addr_o, 0);
                chk("rst_valid", instr_valid_id_o, 0);
                chk("rst_rdata", instr_rdata_id_o, 0);
                chk("rst_pc",    pc_id_o, 0);
                chk("rst_bub",   fetch_bubbles_o, 0);
                bub = '0;
            end else begin
                exp_valid = (sb.size() != 0);
                chk("valid", instr_valid_id_o, exp_valid);
                if (exp_valid && instr_valid_id_o) begin
                    chk("pc_id", pc_id_o, sb[0].pc);
                    chk("rdata_id", instr_rdata_id_o, sb[0].data);
                end
                chk("bubbles", fetch_bubbles_o, bub);
`ifdef IF_PERF_CNT_EN
                if (run && id_ready_i && !exp_valid && bub != 32'hFFFF_FFFF) bub = bub + 1;
`endif
                if (exp_valid && id_ready_i && !branch_i) void'(sb.pop_front());
            end
        end
    end

    // Driver, memory model and fetch-side reference model
    initial begin
        bit    rv, rsp_real, exp_req, granted;
        mreq_t r;
        int    stall;
        stall = 0;
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk_i);
            rst_ni = 1'b0;
            pend.delete();
            sb.delete();
            run = 0;
            mpc = '0;
            branch_i = 1'b0;
            instr_gnt_i = 1'b0;
            instr_rvalid_i = 1'b0;
            id_ready_i = 1'b0;
            boot_addr_i = (ph == 0) ? 32'h80 : 32'hFFFF_FFF1;
            repeat (3) @(negedge clk_i);
            rst_ni = 1'b1;
            for (int c = 0; c < 650; c++) begin
                if (c > 0) @(negedge clk_i);
                branch_i = 1'b0;
                if (ph == 0 && c < 30) begin
                    instr_gnt_i = 1'b1; id_ready_i = 1'b1; rv = 1'b1;
                end else if (ph == 0 && c < 60) begin
                    instr_gnt_i = 1'b1; id_ready_i = 1'b0; rv = 1'b1;
                end else begin
                    if (stall == 0 && $urandom_range(0, 40) == 0) stall = 5;
                    if (stall > 0) begin
                        instr_gnt_i = 1'b0;
                        stall--;
                    end else begin
                        instr_gnt_i = ($urandom_range(0, 2) != 0);
                    end
                    id_ready_i = ($urandom_range(0, 3) != 0);
                    rv = ($urandom_range(0, 3) != 0);
                    if (c > 0 && $urandom_range(0, 19) == 0) begin
                        branch_i = 1'b1;
                        branch_addr_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                                    : $urandom;
                    end
                end
                rsp_real = 1'b0;
                if (rv && pend.size() > 0) begin
                    instr_rvalid_i = 1'b1;
                    instr_rdata_i  = pend[0].data;
                    rsp_real = 1'b1;
                end else if (pend.size() == 0 && c > 60 && $urandom_range(0, 29) == 0) begin
                    instr_rvalid_i = 1'b1;   // stray response, must be ignored
                    instr_rdata_i  = $urandom;
                end else begin
                    instr_rvalid_i = 1'b0;
                end
                #1;
                exp_req = run && (sb.size() + pend.size() < DEPTH) && (pend.size() < MAXO);
                chk("req", instr_req_o, exp_req);
                chk("addr", instr_addr_o, mpc);
                if (ph == 0 && c == 3) begin
                    chk("first_valid", instr_valid_id_o, 1);
                    chk("first_pc", pc_id_o, 32'h80);
                end
                if (ph == 0 && c == 59) chk("full_no_req", instr_req_o, 0);
                #2;
                granted = exp_req && instr_gnt_i;
                if (rsp_real) begin
                    r = pend.pop_front();
                    if (r.ep == epoch && !branch_i) sb.push_back('{pc: r.addr, data: r.data});
                end
                if (granted) pend.push_back('{addr: mpc, data: $urandom, ep: epoch});
                if (!run) begin
                    mpc = boot_addr_i & ~32'h3;
                    run = 1;
                end else if (branch_i) begin
                    sb.delete();
                    epoch++;
                    mpc = branch_addr_i & ~32'h3;
                end else if (granted) begin
                    mpc = mpc + 32'd4;
                end
            end
        end
        @(negedge clk_i);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
